// File: rtl/wb_sram_pkg.sv
// Shared definitions for the Wishbone single-port SRAM bridge.
//   state_t    : bridge FSM state (IDLE, RD_WAIT, ACK), 2-bit encoding
//   WB_SEL_W   : Wishbone byte-lane select width
//   win_bytes  : byte size of the SRAM window for a given word depth
package wb_sram_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    ACK     = 2'd2
  } state_t;

  localparam int WB_SEL_W = 4;

  // Window size in bytes; 32-bit words are 4 bytes each.
  function automatic logic [31:0] win_bytes(input int words);
    return 32'(words * 4);
  endfunction

endpackage

// File: rtl/wb_spsram_bridge.sv
// Wishbone B4 classic slave in front of a 32-bit byte-addressable
// single-port SRAM. Each bus request produces exactly one single-cycle
// SRAM enable. Writes ack one cycle after stb, reads ack two cycles after
// stb, with the SRAM read data registered onto wb_dat_o.
//
// Parameters: WORDS (SRAM depth in words), BASE (byte base of window).
// Ports:
//   clk, rstz          clock, async active-low reset
//   wb_*_i / wb_*_o    Wishbone slave side
//   mem_*              SRAM side (mem_rdata valid 1 cycle after a read enable)
// Build option: define WB_SRAM_ADDR_ERR_EN to decode the address window and
// answer out-of-window requests with wb_err_o instead of aliasing.
module wb_spsram_bridge
  import wb_sram_pkg::*;
#(
  parameter int          WORDS = 256,
  parameter logic [31:0] BASE  = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rstz,
  input  logic [31:0]         wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  input  logic [WB_SEL_W-1:0] wb_sel_i,
  input  logic                wb_we_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  output logic [31:0]         wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata,
  output logic                mem_en,
  output logic                mem_wr_en,
  output logic [WB_SEL_W-1:0] mem_wr_mask
);

  state_t      state, state_nxt;
  logic        req;
  logic        hit;
  logic [31:0] offset;

  assign req    = wb_cyc_i & wb_stb_i;
  // Unsigned wrap of the subtraction turns the two-sided window test into
  // a single compare and keeps BASE near the top of the map safe.
  assign offset = wb_adr_i - BASE;

`ifdef WB_SRAM_ADDR_ERR_EN
  localparam logic [31:0] WINDOW = win_bytes(WORDS);
  assign hit = (offset < WINDOW);
`else
  // No decode: upper address bits fall off in the SRAM and alias.
  assign hit = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (!hit)         state_nxt = ACK;   // error response slot
          else if (wb_we_i) state_nxt = ACK;
          else              state_nxt = RD_WAIT;
        end
      end
      // Master gave up on the read: drop it without acking.
      RD_WAIT: state_nxt = wb_cyc_i ? ACK : IDLE;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // SRAM-side outputs. Only IDLE may enable the SRAM, so the stb still held
  // through RD_WAIT/ACK never issues a second access. rstz gates the enable
  // because state already reads IDLE while reset is held.
  always_comb begin
    mem_addr    = offset;
    mem_wdata   = wb_dat_i;
    mem_wr_mask = wb_sel_i;
    mem_wr_en   = wb_we_i;
    mem_en      = rstz & (state == IDLE) & req & hit;
  end

  // Registered bus responses
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req & hit & wb_we_i) wb_ack_o <= 1'b1;
`ifdef WB_SRAM_ADDR_ERR_EN
          if (req & ~hit)          wb_err_o <= 1'b1;
`endif
        end
        RD_WAIT: begin
          if (wb_cyc_i) begin
            wb_ack_o <= 1'b1;
            wb_dat_o <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
